// File: rtl/psc_trigger_pkg.sv
// Shared frame definition for the psc_trigger serial link (both ends import this).
package psc_trigger_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

   localparam int         DATA_BITS     = 8;
   localparam int         PARITY_EVEN   = 1;
   localparam logic       IDLE_LEVEL    = 1'b1;
   localparam logic [7:0] DEF_TRIG_CODE = 8'hA5;

endpackage

// File: rtl/psc_sync2.sv
// Two-flop synchronizer; resets to the idle line level so no false edge follows reset.
module psc_sync2 import psc_trigger_pkg::*; (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, sync_q;

   // Two-stage capture of the asynchronous line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= IDLE_LEVEL;
         sync_q <= IDLE_LEVEL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/psc_trigger_rx.sv
// Receiver for the psc_trigger serial link: recovers framed bytes, fires trig_out on
// the armed code, and reports parity/framing errors as single-clock pulses.
module psc_trigger_rx import psc_trigger_pkg::*; #(
   parameter int         BIT_CYCLES = 50,
   parameter logic [7:0] TRIG_CODE  = DEF_TRIG_CODE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       psc_input,
   output logic       trig_out,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       busy
);

   localparam int            CW       = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] MID      = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [CW-1:0] LAST     = CW'(BIT_CYCLES - 1);
   localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);
   localparam logic          PAR_INV  = (PARITY_EVEN != 0) ? 1'b0 : 1'b1;

   logic                 line_s, prev_q;
   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_err_q, par_err_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic                 trig_q, trig_d, valid_q, valid_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d;

   psc_sync2 u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (psc_input),
      .q_o   (line_s)
   );

   // State, counters, data and registered output pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q    <= IDLE_LEVEL;
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         par_err_q <= 1'b0;
         rx_data_q <= '0;
         trig_q    <= 1'b0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         prev_q    <= line_s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         par_err_q <= par_err_d;
         rx_data_q <= rx_data_d;
         trig_q    <= trig_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   // Frame sequencing: START samples at mid-bit, later bits one bit-time apart.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      par_err_d = par_err_q;
      rx_data_d = rx_data_q;
      trig_d    = 1'b0;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (prev_q && !line_s) state_d = START;
         end
         START: begin
            if (cnt_q == MID) begin
               cnt_d   = '0;
               idx_d   = '0;
               // A line back high by mid-bit was a glitch, not a start bit.
               state_d = line_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA, PARITY, STOP: begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               if (state_q == DATA) begin
                  shreg_d = {line_s, shreg_q[DATA_BITS-1:1]};
                  idx_d   = idx_q + 3'd1;
                  if (idx_q == LAST_IDX) state_d = PARITY;
               end else if (state_q == PARITY) begin
                  par_err_d = line_s ^ (^shreg_q) ^ PAR_INV;
                  state_d   = STOP;
               end else if (line_s == IDLE_LEVEL) begin
                  if (par_err_q) begin
                     perr_d = 1'b1;
                  end else begin
                     rx_data_d = shreg_q;
                     valid_d   = 1'b1;
                     trig_d    = (shreg_q == TRIG_CODE);
                  end
                  state_d = IDLE;
               end else begin
                  // Framing error wins over parity; wait out the low line in BREAK.
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (line_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign trig_out     = trig_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = valid_q;
   assign parity_error = perr_q;
   assign frame_error  = ferr_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_psc_trigger_rx.sv
// Directed bench for psc_trigger_rx at the default 50 clocks per bit.
module tb_psc_trigger_rx;

   localparam int BC = 50;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       psc_input = 1'b1;
   logic       trig_out, rx_valid, parity_error, frame_error, busy;
   logic [7:0] rx_data;

   int nvec = 0, nerr = 0;
   int cyc = 0, start_cyc = 0, trig_cyc = 0;
   int n_trig = 0, n_val = 0, n_perr = 0, n_ferr = 0, n_busy = 0;
   int b_trig, b_val, b_perr, b_ferr, b_busy;

   psc_trigger_rx #(.BIT_CYCLES(BC), .TRIG_CODE(8'hA5)) dut (
      .clk          (clk),
      .reset        (reset),
      .psc_input    (psc_input),
      .trig_out     (trig_out),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .parity_error (parity_error),
      .frame_error  (frame_error),
      .busy         (busy)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse/busy tallies sampled on the falling edge.
   always @(negedge clk) begin
      if (trig_out) begin n_trig++; trig_cyc = cyc; end
      if (rx_valid) n_val++;
      if (parity_error) n_perr++;
      if (frame_error) n_ferr++;
      if (busy) n_busy++;
   end

   task automatic snap();
      b_trig = n_trig; b_val = n_val; b_perr = n_perr; b_ferr = n_ferr; b_busy = n_busy;
   endtask

   // All drive tasks start and end at posedge+1.
   task automatic drive_bit(input logic b, input int n);
      psc_input = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      start_cyc = cyc;
      drive_bit(1'b0, BC);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BC);
      drive_bit(par, BC);
      drive_bit(stp, BC);
      psc_input = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; psc_input = 1'b1;
      #1000;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy_in_reset got %b want 0", busy); end
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (5) @(posedge clk); #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
      nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      nvec++; if ({trig_out, rx_valid, parity_error, frame_error} !== 4'b0000) begin
         nerr++; $display("FAIL reset_pulses got %b want 0000", {trig_out, rx_valid, parity_error, frame_error}); end
   endtask

   task automatic test_trigger();
      int lat;
      snap();
      send_frame(8'hA5, 1'b0, 1'b1);
      drive_bit(1'b1, 10);
      lat = trig_cyc - start_cyc;
      nvec++; if (n_trig - b_trig !== 1) begin nerr++; $display("FAIL trig_count got %0d want 1", n_trig - b_trig); end
      nvec++; if (n_val - b_val !== 1) begin nerr++; $display("FAIL trig_valid_count got %0d want 1", n_val - b_val); end
      nvec++; if (lat < 526 || lat > 528) begin nerr++; $display("FAIL trig_latency got %0d want 527+-1", lat); end
      nvec++; if (rx_data !== 8'hA5) begin nerr++; $display("FAIL trig_rx_data got %h want a5", rx_data); end
      nvec++; if ((n_perr - b_perr) + (n_ferr - b_ferr) !== 0) begin nerr++; $display("FAIL trig_errors got %0d want 0", (n_perr - b_perr) + (n_ferr - b_ferr)); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL trig_busy_after got %b want 0", busy); end
   endtask

   task automatic test_nontrig();
      snap();
      send_frame(8'h3C, 1'b0, 1'b1);
      drive_bit(1'b1, 10);
      nvec++; if (n_val - b_val !== 1) begin nerr++; $display("FAIL nontrig_valid got %0d want 1", n_val - b_val); end
      nvec++; if (n_trig - b_trig !== 0) begin nerr++; $display("FAIL nontrig_trig got %0d want 0", n_trig - b_trig); end
      nvec++; if (rx_data !== 8'h3C) begin nerr++; $display("FAIL nontrig_rx_data got %h want 3c", rx_data); end
   endtask

   task automatic test_parity();
      snap();
      send_frame(8'hA5, 1'b1, 1'b1);
      drive_bit(1'b1, 10);
      nvec++; if (n_perr - b_perr !== 1) begin nerr++; $display("FAIL parity_pulse got %0d want 1", n_perr - b_perr); end
      nvec++; if ((n_val - b_val) + (n_trig - b_trig) + (n_ferr - b_ferr) !== 0) begin
         nerr++; $display("FAIL parity_other_pulses got %0d want 0", (n_val - b_val) + (n_trig - b_trig) + (n_ferr - b_ferr)); end
      nvec++; if (rx_data !== 8'h3C) begin nerr++; $display("FAIL parity_rx_data got %h want 3c", rx_data); end
   endtask

   task automatic test_back_to_back();
      snap();
      send_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'hA5, 1'b0, 1'b1);
      drive_bit(1'b1, 10);
      nvec++; if (n_val - b_val !== 2) begin nerr++; $display("FAIL b2b_valid got %0d want 2", n_val - b_val); end
      nvec++; if (n_trig - b_trig !== 1) begin nerr++; $display("FAIL b2b_trig got %0d want 1", n_trig - b_trig); end
      nvec++; if (rx_data !== 8'hA5) begin nerr++; $display("FAIL b2b_rx_data got %h want a5", rx_data); end
   endtask

   task automatic test_break();
      snap();
      send_frame(8'hA5, 1'b0, 1'b0);
      drive_bit(1'b0, 2000);
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL break_busy_low got %b want 1", busy); end
      nvec++; if (n_ferr - b_ferr !== 1) begin nerr++; $display("FAIL break_frame_err got %0d want 1", n_ferr - b_ferr); end
      nvec++; if ((n_perr - b_perr) + (n_val - b_val) + (n_trig - b_trig) !== 0) begin
         nerr++; $display("FAIL break_other_pulses got %0d want 0", (n_perr - b_perr) + (n_val - b_val) + (n_trig - b_trig)); end
      nvec++; if (rx_data !== 8'hA5) begin nerr++; $display("FAIL break_rx_data got %h want a5", rx_data); end
      drive_bit(1'b1, 5);
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL break_busy_release got %b want 0", busy); end
   endtask

   task automatic test_glitch();
      int bz;
      snap();
      drive_bit(1'b0, 10);
      drive_bit(1'b1, 60);
      bz = n_busy - b_busy;
      nvec++; if (bz < 1 || bz > 26) begin nerr++; $display("FAIL glitch_busy_cycles got %0d want 1..26", bz); end
      nvec++; if ((n_trig - b_trig) + (n_val - b_val) + (n_perr - b_perr) + (n_ferr - b_ferr) !== 0) begin
         nerr++; $display("FAIL glitch_pulses got %0d want 0", (n_trig - b_trig) + (n_val - b_val) + (n_perr - b_perr) + (n_ferr - b_ferr)); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'hA5;
      snap();
      drive_bit(1'b0, BC);
      for (int i = 0; i < 4; i++) drive_bit(d[i], BC);
      drive_bit(d[4], BC / 2);
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
      reset = 1'b0; psc_input = 1'b1;
      repeat (5) @(posedge clk); #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy_in_reset got %b want 0", busy); end
      nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL rstmid_rx_data_cleared got %h want 00", rx_data); end
      reset = 1'b1;
      drive_bit(1'b1, 60);
      nvec++; if ((n_trig - b_trig) + (n_val - b_val) + (n_perr - b_perr) + (n_ferr - b_ferr) !== 0) begin
         nerr++; $display("FAIL rstmid_partial_pulses got %0d want 0", (n_trig - b_trig) + (n_val - b_val) + (n_perr - b_perr) + (n_ferr - b_ferr)); end
      send_frame(8'hA5, 1'b0, 1'b1);
      drive_bit(1'b1, 10);
      nvec++; if (n_trig - b_trig !== 1) begin nerr++; $display("FAIL rstmid_trig got %0d want 1", n_trig - b_trig); end
      nvec++; if (rx_data !== 8'hA5) begin nerr++; $display("FAIL rstmid_rx_data got %h want a5", rx_data); end
   endtask

   initial begin
      test_reset();
      test_trigger();
      test_nontrig();
      test_parity();
      test_back_to_back();
      test_break();
      test_glitch();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
